// File: rtl/ssd_scan_capture.sv
// Rebuilds the 4-digit BCD value shown on a multiplexed active-low seven-segment
// display by sampling its anode and cathode lines on the shared scan clock.
module ssd_scan_capture #(
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic [3:0]  AN_IN,
    input  logic [6:0]  SEG_IN,
    output logic [15:0] DOUT,
    output logic        DVALID,
    output logic        DUPD,
    output logic        ERR
);

    localparam logic [3:0]  HOLD_C = 4'(HOLD);
    localparam logic [15:0] TMO_C  = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        LOCKED
    } state_t;

    state_t      state;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic        prev_ok;
    logic [1:0]  prev_idx;
    logic [6:0]  prev_seg;
    logic [3:0]  run;
    logic [15:0] tmo;
    logic [3:0]  mask;
    logic [15:0] shadow;

    logic        idx_ok;
    logic [1:0]  idx;
    logic        dig_ok;
    logic [3:0]  nib;
    logic        same;
    logic [3:0]  run_next;
    logic        accept;
    logic        good;
    logic        bad;
    logic [15:0] tmo_next;
    logic        expire;
    logic [3:0]  mask_new;
    logic [15:0] frame;

    // Only a single low anode line names a digit; blank and multi-select are unusable.
    always_comb begin
        idx_ok = 1'b1;
        idx    = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx_ok = 1'b0;
        endcase
    end

    always_comb begin
        dig_ok = 1'b1;
        nib    = 4'd0;
        case (seg_q)
            7'b1000000: nib = 4'd0;
            7'b1111001: nib = 4'd1;
            7'b0100100: nib = 4'd2;
            7'b0110000: nib = 4'd3;
            7'b0011001: nib = 4'd4;
            7'b0010010: nib = 4'd5;
            7'b0000010: nib = 4'd6;
            7'b1111000: nib = 4'd7;
            7'b0000000: nib = 4'd8;
            7'b0010000: nib = 4'd9;
            default:    dig_ok = 1'b0;
        endcase
    end

    // The run fires once when it first reaches HOLD; a saturated run at HOLD=15 stays quiet.
    always_comb begin
        same     = idx_ok && prev_ok && (idx == prev_idx) && (seg_q == prev_seg);
        run_next = 4'd0;
        if (idx_ok) begin
            if (same)
                run_next = (run == 4'd15) ? run : run + 4'd1;
            else
                run_next = 4'd1;
        end
        accept   = idx_ok && (run_next == HOLD_C) && !(same && (run == HOLD_C));
        good     = accept && dig_ok;
        bad      = accept && !dig_ok;
        tmo_next = good ? 16'd0 : ((tmo == TMO_C) ? tmo : tmo + 16'd1);
        expire   = !good && (tmo_next == TMO_C);
        mask_new = mask | (4'b0001 << idx);
        frame    = shadow;
        frame[{idx, 2'b00} +: 4] = nib;
    end

    always_ff @(posedge DCLK) begin
        if (RST) begin
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
            prev_ok  <= 1'b0;
            prev_idx <= 2'd0;
            prev_seg <= 7'b1111111;
            run      <= 4'd0;
            tmo      <= 16'd0;
            mask     <= 4'd0;
            shadow   <= 16'd0;
            state    <= IDLE;
            DOUT     <= 16'd0;
            DVALID   <= 1'b0;
            DUPD     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            an_q     <= AN_IN;
            seg_q    <= SEG_IN;
            prev_ok  <= idx_ok;
            prev_idx <= idx;
            prev_seg <= seg_q;
            run      <= run_next;
            tmo      <= tmo_next;
            ERR      <= bad;
            DUPD     <= 1'b0;
            if (expire) begin
                state  <= IDLE;
                mask   <= 4'd0;
                DVALID <= 1'b0;
            end else if (good) begin
                case (state)
                    IDLE: begin
                        // A frame may only start at the least significant digit.
                        if (idx == 2'd0) begin
                            shadow <= frame;
                            mask   <= 4'b0001;
                            state  <= COLLECT;
                        end
                    end
                    default: begin
                        shadow <= frame;
                        if (mask_new == 4'b1111) begin
                            DOUT   <= frame;
                            DVALID <= 1'b1;
                            DUPD   <= !DVALID || (frame != DOUT);
                            mask   <= 4'd0;
                            state  <= LOCKED;
                        end else begin
                            mask <= mask_new;
                        end
                    end
                endcase
            end
        end
    end

endmodule
